// File: rtl/cont_bwd_if.sv
// cont_bwd_if: control/strobe bundle between the backward controller and its SRAMs/datapath
interface cont_bwd_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              hold;
  logic              alpha_rd_en;
  logic [ADDR_W-1:0] alpha_addr;
  logic              beta_w_r;
  logic [ADDR_W-1:0] beta_addr;
  logic              beta_init;
  logic              add_en;
  logic              cmp_en;
  logic              llr_valid;
  logic [7:0]        llr_idx;
  logic              busy;
  logic              done_bwd;
  modport master (
    input  start, hold,
    output alpha_rd_en, alpha_addr, beta_w_r, beta_addr, beta_init,
           add_en, cmp_en, llr_valid, llr_idx, busy, done_bwd
  );
  modport slave (
    output start, hold,
    input  alpha_rd_en, alpha_addr, beta_w_r, beta_addr, beta_init,
           add_en, cmp_en, llr_valid, llr_idx, busy, done_bwd
  );
endinterface

// File: rtl/cont_bwd.sv
// cont_bwd: beta-recursion / LLR sequencer, walks stages N_STAGES-1 down to 1
module cont_bwd #(
  parameter int N_STAGES = 8,
  parameter int ADDR_W   = 8,
  parameter int STRIDE   = 8
) (
  input  logic       clk,
  input  logic       rst,
  cont_bwd_if.master bus
);
  typedef enum logic [2:0] {IDLE, INIT, RD, ADD, CMP, WR, LLR, DONE} state_t;
  state_t state, nxt;
  logic [7:0] k, nxt_k;
  logic [ADDR_W-1:0] a_k, a_km1;
  logic [ADDR_W-1:0] alpha_addr_d, beta_addr_d;
  logic [7:0] llr_idx_d;
  logic alpha_rd_en_d, beta_w_r_d, beta_init_d, add_en_d, cmp_en_d;
  logic llr_valid_d, busy_d, done_d;
  // outputs are decoded from the next state so they are registered yet valid in that state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= IDLE;
      k               <= '0;
      bus.alpha_rd_en <= 1'b0;
      bus.alpha_addr  <= '0;
      bus.beta_w_r    <= 1'b0;
      bus.beta_addr   <= '0;
      bus.beta_init   <= 1'b0;
      bus.add_en      <= 1'b0;
      bus.cmp_en      <= 1'b0;
      bus.llr_valid   <= 1'b0;
      bus.llr_idx     <= '0;
      bus.busy        <= 1'b0;
      bus.done_bwd    <= 1'b0;
    end else if (!bus.hold) begin
      state           <= nxt;
      k               <= nxt_k;
      bus.alpha_rd_en <= alpha_rd_en_d;
      bus.alpha_addr  <= alpha_addr_d;
      bus.beta_w_r    <= beta_w_r_d;
      bus.beta_addr   <= beta_addr_d;
      bus.beta_init   <= beta_init_d;
      bus.add_en      <= add_en_d;
      bus.cmp_en      <= cmp_en_d;
      bus.llr_valid   <= llr_valid_d;
      bus.llr_idx     <= llr_idx_d;
      bus.busy        <= busy_d;
      bus.done_bwd    <= done_d;
    end
  always_comb begin
    nxt   = state == IDLE ? (bus.start ? INIT : IDLE) :
            state == LLR  ? (k == 8'd1 ? DONE : RD) :
            state == DONE ? IDLE : state_t'(state + 3'd1);
    nxt_k = (state == IDLE && bus.start) ? 8'(N_STAGES - 1) :
            (state == LLR && k != 8'd1)  ? k - 8'd1 : k;
  end
  always_comb begin
    a_k           = ADDR_W'(int'(nxt_k) * STRIDE);
    a_km1         = ADDR_W'((int'(nxt_k) - 1) * STRIDE);
    alpha_rd_en_d = nxt == RD;
    alpha_addr_d  = nxt == RD ? a_km1 : '0;
    beta_w_r_d    = nxt == INIT || nxt == WR;
    beta_addr_d   = (nxt == INIT || nxt == RD) ? a_k : nxt == WR ? a_km1 : '0;
    beta_init_d   = nxt == INIT;
    add_en_d      = nxt == ADD;
    cmp_en_d      = nxt == CMP;
    llr_valid_d   = nxt == LLR;
    llr_idx_d     = nxt == LLR ? nxt_k : '0;
    busy_d        = nxt != IDLE;
    done_d        = nxt == DONE;
  end
endmodule
